imem_loader: RTL and testbench



---
 rtl/imem_loader.sv | 104 ++++++++++
 tb/tb_imem_loader.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader that writes instruction memory and holds the core until the checksum verifies
module imem_loader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int MAX_WORDS = 4096
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   words_loaded
);
  typedef enum logic [2:0] {IDLE, CNT_H, CNT_L, DAT_H, DAT_L, WRITE, CHK, ERROR} state_t;
  localparam logic [15:0] MAX16 = 16'(MAX_WORDS);
  state_t state, nxt;
  logic [7:0] cnt_hi, dat_hi, chk;
  logic [ADDR_W:0] cnt, wl_next;
  logic [15:0] cnt_full;
  logic xfer, sync, bad_cnt;
  assign xfer = rx_valid && rx_ready;
  assign sync = xfer && rx_data == SYNC_BYTE;
  assign cnt_full = {cnt_hi, rx_data};
  assign bad_cnt = cnt_full == '0 || cnt_full > MAX16;
  assign wl_next = words_loaded + (ADDR_W+1)'(1);
  // state register
  always_ff @(posedge CLOCK_50)
    state <= reset ? IDLE : nxt;
  // next-state: one step per accepted byte, WRITE always lasts one cycle
  always_comb begin
    nxt = state;
    case (state)
      IDLE, ERROR: nxt = sync ? CNT_H : state;
      CNT_H:       nxt = xfer ? CNT_L : state;
      CNT_L:       nxt = xfer ? (bad_cnt ? ERROR : DAT_H) : state;
      DAT_H:       nxt = xfer ? DAT_L : state;
      DAT_L:       nxt = xfer ? WRITE : state;
      WRITE:       nxt = wl_next == cnt ? CHK : DAT_H;
      CHK:         nxt = xfer ? (rx_data == chk ? IDLE : ERROR) : state;
    endcase
  end
  // outputs decoded from state: the only stall is the write cycle
  always_comb begin
    rx_ready = state != WRITE;
    mem_wren = state == WRITE;
  end
  // datapath: byte assembly, checksum, word counter and sticky status
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cnt_hi       <= '0;
      dat_hi       <= '0;
      chk          <= '0;
      cnt          <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_hold     <= 1'b0;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      words_loaded <= '0;
    end else begin
      case (state)
        IDLE, ERROR: if (sync) begin
          cpu_hold     <= 1'b1;
          load_done    <= 1'b0;
          load_error   <= 1'b0;
          words_loaded <= '0;
          chk          <= '0;
        end
        CNT_H: if (xfer) begin
          cnt_hi <= rx_data;
          chk    <= chk ^ rx_data;
        end
        CNT_L: if (xfer) begin
          cnt        <= cnt_full[ADDR_W:0];
          chk        <= chk ^ rx_data;
          load_error <= bad_cnt;
        end
        DAT_H: if (xfer) begin
          dat_hi <= rx_data;
          chk    <= chk ^ rx_data;
        end
        DAT_L: if (xfer) begin
          mem_wdata <= {dat_hi, rx_data};
          mem_addr  <= words_loaded[ADDR_W-1:0];
          chk       <= chk ^ rx_data;
        end
        WRITE: words_loaded <= wl_next;
        CHK: if (xfer) begin
          load_done  <= rx_data == chk;
          load_error <= rx_data != chk;
          cpu_hold   <= rx_data != chk;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized frame stimulus against a frame-level model with a per-cycle write scoreboard
module tb_imem_loader;
  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_wren;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;
  logic [12:0] words_loaded;
  int vectors = 0;
  int miscompares = 0;
  bit running = 0;
  logic [7:0]  tx_q[$];
  bit          wf_q[$];
  logic [27:0] exp_q[$];
  logic [15:0] wq[$];
  bit e_done, e_err, e_hold;
  int e_wl;

  imem_loader dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error),
    .words_loaded(words_loaded)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  initial begin
    #(20 * 60000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // every cycle: ready is low only on write cycles, and each write matches the next expected word
  always @(negedge CLOCK_50) begin
    if (running && !reset) begin
      check("rx_ready_vs_wren", rx_ready, !mem_wren);
      if (mem_wren) begin
        check("write_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          check("write_addr", mem_addr, exp_q[0][27:16]);
          check("write_data", mem_wdata, exp_q[0][15:0]);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // frame model: builds the byte stream, the expected writes and the expected final status
  task automatic build(input int cnt, input bit bad, input bit incr);
    logic [7:0] x;
    logic [15:0] w;
    logic [15:0] c;
    bit legal;
    c = 16'(cnt);
    legal = cnt > 0 && cnt <= 4096;
    x = c[15:8] ^ c[7:0];
    tx_q.push_back(8'hA5); wf_q.push_back(0);
    tx_q.push_back(c[15:8]); wf_q.push_back(0);
    tx_q.push_back(c[7:0]); wf_q.push_back(0);
    if (legal) begin
      for (int i = 0; i < cnt; i++) begin
        if (wq.size() != 0) w = wq.pop_front();
        else if (incr) w = 16'(i);
        else w = 16'($urandom);
        tx_q.push_back(w[15:8]); wf_q.push_back(0);
        tx_q.push_back(w[7:0]); wf_q.push_back(1);
        x ^= w[15:8] ^ w[7:0];
        exp_q.push_back({12'(i), w});
      end
      tx_q.push_back(bad ? x ^ 8'h01 : x); wf_q.push_back(0);
    end
    e_done = legal && !bad;
    e_err = !e_done;
    e_hold = !e_done;
    e_wl = legal ? cnt : 0;
  endtask

  task automatic send(input int gap_max, input int n);
    while (n > 0 && tx_q.size() != 0) begin
      int g;
      int t;
      bit wf;
      g = $urandom_range(gap_max, 0);
      if (g > 0) begin
        rx_valid = 1'b0;
        repeat (g) @(negedge CLOCK_50);
      end
      rx_data = tx_q.pop_front();
      wf = wf_q.pop_front();
      rx_valid = 1'b1;
      t = 0;
      while (!rx_ready && t < 20) begin
        @(negedge CLOCK_50);
        t++;
      end
      if (t >= 20) check("ready_timeout", t, 0);
      @(negedge CLOCK_50);
      if (wf) check("wren_latency", mem_wren, 1);
      n--;
    end
    rx_valid = 1'b0;
  endtask

  task automatic status(input string tag);
    check({tag, "_done"}, load_done, e_done);
    check({tag, "_error"}, load_error, e_err);
    check({tag, "_hold"}, cpu_hold, e_hold);
    check({tag, "_words"}, words_loaded, e_wl);
    check({tag, "_pending"}, exp_q.size(), 0);
  endtask

  task automatic reset_values(input string tag);
    check({tag, "_rx_ready"}, rx_ready, 1);
    check({tag, "_wren"}, mem_wren, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_wdata"}, mem_wdata, 0);
    check({tag, "_hold"}, cpu_hold, 0);
    check({tag, "_done"}, load_done, 0);
    check({tag, "_error"}, load_error, 0);
    check({tag, "_words"}, words_loaded, 0);
  endtask

  initial begin
    repeat (3) @(negedge CLOCK_50);
    reset_values("rst");
    reset = 1'b0;
    running = 1;
    @(negedge CLOCK_50);
    wq = '{16'h1234, 16'hABCD};
    build(2, 0, 0);
    check("model_len", tx_q.size(), 8);
    check("model_chk", tx_q[7], 8'h42);
    send(0, 1000);
    status("good2");
    check("good2_hold_lit", cpu_hold, 0);
    check("good2_words_lit", words_loaded, 2);
    wq = '{16'h1234, 16'hABCD};
    build(2, 1, 0);
    check("bad_chk_lit", tx_q[7], 8'h43);
    send(0, 1000);
    status("badchk");
    wq = '{16'h1234, 16'hABCD};
    build(2, 0, 0);
    send(2, 1000);
    status("recover");
    build(0, 0, 0);
    send(1, 1000);
    status("cnt0");
    build(4097, 0, 0);
    send(1, 1000);
    status("cnt4097");
    check("cnt4097_err_lit", load_error, 1);
    wq = '{16'hA5A5};
    build(1, 0, 0);
    send(0, 1000);
    status("sync_as_data");
    build(1, 0, 0);
    send(0, 3);
    repeat (40) @(negedge CLOCK_50);
    check("stall_hold", cpu_hold, 1);
    check("stall_done", load_done, 0);
    check("stall_words", words_loaded, 0);
    send(3, 1000);
    status("stall");
    for (int k = 0; k < 8; k++) begin
      build($urandom_range(24, 0), $urandom_range(3, 0) == 0, 0);
      send($urandom_range(3, 0), 1000);
      status("rand");
    end
    build(3, 0, 0);
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    send(0, 5);
    @(negedge CLOCK_50);
    check("midframe_words", words_loaded, 1);
    reset = 1'b1;
    @(negedge CLOCK_50);
    reset_values("midrst");
    reset = 1'b0;
    tx_q.delete();
    wf_q.delete();
    check("midrst_pending", exp_q.size(), 0);
    tx_q.push_back(8'h00); wf_q.push_back(0);
    tx_q.push_back(8'hFF); wf_q.push_back(0);
    build(3, 0, 0);
    send(1, 1000);
    status("junk");
    build(4096, 0, 1);
    send(0, 100000);
    status("max");
    check("max_last_addr", mem_addr, 12'hFFF);
    check("max_last_data", mem_wdata, 16'h0FFF);
    repeat (3) @(negedge CLOCK_50);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
